// File: rtl/cpc_mem_arbiter_if.sv
// Shared 16-bit memory port between the arbiter (master) and the SDRAM controller (slave).
interface cpc_mem_arbiter_if;
  localparam int unsigned MA_W = 22;
  localparam int unsigned DW   = 16;

  logic            mem_req;
  logic            mem_we;
  logic [MA_W-1:0] mem_addr;
  logic [1:0]      mem_be;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpc_mem_arbiter.sv
// Video / CPU / loader arbiter for the single shared memory port, one transaction at a time.
// Optional MEM_WATCHDOG_EN: abandons a WAIT that never sees mem_ack and sets sticky timeout.
module cpc_mem_arbiter #(
  parameter int unsigned AGE_LIMIT = 8,
  parameter int unsigned WD_CYCLES = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic [15:0] vid_dout,
  output logic        vid_valid,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        ld_wr,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_busy,
  output logic        timeout,
  cpc_mem_arbiter_if.master mem
);
  localparam int unsigned VA_W  = 15;
  localparam int unsigned CA_W  = 23;
  localparam int unsigned MA_W  = 22;
  localparam int unsigned DW    = 16;
  localparam int unsigned BW    = 8;
  localparam int unsigned AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_VID, S_CPU, S_LD, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_LD} owner_t;

  state_t            state_q, state_d;
  owner_t            own_q, own_d;
  logic              cpu_lvl_q, cpu_pend_q, cpu_pend_d, cpu_we_q, cpu_we_d;
  logic [CA_W-1:0]   cpu_addr_q, cpu_addr_d, ld_addr_q, ld_addr_d;
  logic [BW-1:0]     cpu_din_q, cpu_din_d, ld_data_q, ld_data_d;
  logic              ld_busy_q, ld_busy_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [DW-1:0]     vid_dout_q, vid_dout_d;
  logic              vid_valid_q, vid_valid_d, cpu_ack_q, cpu_ack_d;
  logic [BW-1:0]     cpu_dout_q, cpu_dout_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              cpu_lvl, xfer_done;
  logic [DW-1:0]     rd_word;

`ifdef MEM_WATCHDOG_EN
  localparam int unsigned WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign cpu_lvl = cpu_rd | cpu_wr;

  // Next-state, grant selection, completion and request capture
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    cpu_pend_d  = cpu_pend_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_din_d   = cpu_din_q;
    ld_busy_d   = ld_busy_q;
    ld_addr_d   = ld_addr_q;
    ld_data_d   = ld_data_q;
    age_d       = age_q;
    vid_dout_d  = vid_dout_q;
    cpu_dout_d  = cpu_dout_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    xfer_done   = 1'b0;
    rd_word     = mem.mem_rdata;
`ifdef MEM_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (vid_req) begin
          state_d     = S_VID;
          own_d       = OWN_VID;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {7'b0, vid_addr[VA_W-1:0]};
          mem_be_d    = 2'b11;
        end else if (ld_busy_q && (age_q >= AGE_LIM || !cpu_pend_q)) begin
          state_d     = S_LD;
          own_d       = OWN_LD;
          age_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ld_addr_q[CA_W-1:1];
          mem_be_d    = ld_addr_q[0] ? 2'b10 : 2'b01;
          mem_wdata_d = {ld_data_q, ld_data_q};
        end else if (cpu_pend_q) begin
          state_d     = S_CPU;
          own_d       = OWN_CPU;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we_q;
          mem_addr_d  = cpu_addr_q[CA_W-1:1];
          mem_be_d    = cpu_addr_q[0] ? 2'b10 : 2'b01;
          mem_wdata_d = {cpu_din_q, cpu_din_q};
          if (ld_busy_q && age_q != AGE_MAX) age_d = age_q + 4'd1;
        end
      end
      S_VID, S_CPU, S_LD: begin
        state_d = S_WAIT;
`ifdef MEM_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          xfer_done = 1'b1;
`ifdef MEM_WATCHDOG_EN
        end else if (wd_cnt_q == WD_LAST) begin
          // Abandoned transaction still completes toward the requester, with all-ones data
          xfer_done = 1'b1;
          rd_word   = '1;
          timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer_done) begin
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
      unique case (own_q)
        OWN_VID: begin
          vid_dout_d  = rd_word;
          vid_valid_d = 1'b1;
        end
        OWN_CPU: begin
          cpu_ack_d  = 1'b1;
          cpu_pend_d = 1'b0;
          if (!mem_we_q) cpu_dout_d = mem_be_q[1] ? rd_word[15:8] : rd_word[7:0];
        end
        default: ld_busy_d = 1'b0;
      endcase
    end

    // A new CPU edge wins over a same-cycle completion so it is never lost
    if (cpu_lvl && !cpu_lvl_q) begin
      cpu_pend_d = 1'b1;
      cpu_we_d   = cpu_wr;
      cpu_addr_d = cpu_addr;
      cpu_din_d  = cpu_din;
    end

    if (ld_wr && !ld_busy_q) begin
      ld_busy_d = 1'b1;
      ld_addr_d = ld_addr;
      ld_data_d = ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      own_q       <= OWN_VID;
      cpu_lvl_q   <= 1'b0;
      cpu_pend_q  <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_din_q   <= '0;
      ld_busy_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      age_q       <= '0;
      vid_dout_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= 8'hFF;
      cpu_ack_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_WATCHDOG_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      cpu_lvl_q   <= cpu_lvl;
      cpu_pend_q  <= cpu_pend_d;
      cpu_we_q    <= cpu_we_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_din_q   <= cpu_din_d;
      ld_busy_q   <= ld_busy_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      age_q       <= age_d;
      vid_dout_q  <= vid_dout_d;
      vid_valid_q <= vid_valid_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign vid_dout      = vid_dout_q;
  assign vid_valid     = vid_valid_q;
  assign cpu_dout      = cpu_dout_q;
  assign cpu_ack       = cpu_ack_q;
  assign ld_busy       = ld_busy_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

`ifdef MEM_WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// Scoreboard bench for cpc_mem_arbiter; watchdog cases follow MEM_WATCHDOG_EN.
module tb_cpc_mem_arbiter;
  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } cpu_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [14:0] vid_addr = '0;
  logic [15:0] vid_dout;
  logic        vid_valid;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        ld_wr = 1'b0;
  logic [22:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_busy;
  logic        timeout;

  cpc_mem_arbiter_if mem_bus ();

  cpc_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
    .timeout(timeout), .mem(mem_bus)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;
  int txn_cnt = 0, cpu_ack_cnt = 0;
  mem_exp_t exp_mem[$];
  cpu_exp_t exp_cpu[$];
  logic [15:0] exp_vid[$];

  // Memory responder controls
  bit          no_ack = 1'b0;
  int          mem_lat = 2;
  bit          use_fixed = 1'b0;
  logic [15:0] fixed_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_exp_t byte_txn(input logic we, input logic [22:0] a, input logic [7:0] d);
    mem_exp_t e;
    e.we    = we;
    e.addr  = a[22:1];
    e.be    = a[0] ? 2'b10 : 2'b01;
    e.wdata = {d, d};
    return e;
  endfunction

  function automatic mem_exp_t vid_txn(input logic [14:0] a);
    mem_exp_t e;
    e.we    = 1'b0;
    e.addr  = {7'b0, a};
    e.be    = 2'b11;
    e.wdata = '0;
    return e;
  endfunction

  // Memory model: acks mem_lat cycles after mem_req is first seen
  initial begin
    int  cnt;
    bit  acked;
    cnt = 0;
    acked = 1'b0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_bus.mem_ack = 1'b0;
      if (reset || !mem_bus.mem_req) begin
        cnt = 0;
        acked = 1'b0;
      end else if (!acked && !no_ack) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_bus.mem_ack = 1'b1;
          mem_bus.mem_rdata = use_fixed ? fixed_word : (mem_bus.mem_addr[15:0] ^ 16'hC33C);
          acked = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction or completion
  initial begin
    logic     prev_req;
    mem_exp_t em;
    cpu_exp_t ec;
    logic [15:0] ev;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (mem_bus.mem_req && !prev_req) begin
          txn_cnt++;
          if (exp_mem.size() == 0) check("unexpected_txn", 32'd1, 32'd0);
          else begin
            em = exp_mem.pop_front();
            check("txn_we", 32'(mem_bus.mem_we), 32'(em.we));
            check("txn_addr", 32'(mem_bus.mem_addr), 32'(em.addr));
            check("txn_be", 32'(mem_bus.mem_be), 32'(em.be));
            if (em.we) check("txn_wdata", 32'(mem_bus.mem_wdata), 32'(em.wdata));
          end
        end
        prev_req = mem_bus.mem_req;
        if (cpu_ack) begin
          cpu_ack_cnt++;
          if (exp_cpu.size() == 0) check("unexpected_cpu_ack", 32'd1, 32'd0);
          else begin
            ec = exp_cpu.pop_front();
            if (ec.chk) check("cpu_dout", 32'(cpu_dout), 32'(ec.val));
          end
        end
        if (vid_valid) begin
          if (exp_vid.size() == 0) check("unexpected_vid_valid", 32'd1, 32'd0);
          else begin
            ev = exp_vid.pop_front();
            check("vid_dout", 32'(vid_dout), 32'(ev));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_ack(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      tick();
      if (cpu_ack) break;
    end
    check(name, 32'(cpu_ack), 32'd1);
  endtask

  task automatic push_cpu(input logic chk, input logic [7:0] v);
    cpu_exp_t e;
    e.chk = chk;
    e.val = v;
    exp_cpu.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0, a0, hc;

    // Reset values
    tick(); tick();
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ld_busy", 32'(ld_busy), 32'd0);
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_bus.mem_be), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("rst_vid_dout", 32'(vid_dout), 32'd0);
    check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_bus.mem_wdata), 32'd0);
    reset = 1'b0;
    tick();

    // CPU read of an odd byte, memory answers A55A
    use_fixed = 1'b1; fixed_word = 16'hA55A; mem_lat = 3;
    exp_mem.push_back('{we: 1'b0, addr: 22'h000080, be: 2'b10, wdata: 16'h0000});
    push_cpu(1'b1, 8'hA5);
    t0 = txn_cnt;
    cpu_addr = 23'h000101; cpu_rd = 1'b1;
    wait_cpu_ack("rd_ack_seen", 100);
    tick();
    check("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    repeat (10) tick();
    check("rd_held_no_rerequest", 32'(txn_cnt), 32'(t0 + 1));
    cpu_rd = 1'b0; use_fixed = 1'b0; mem_lat = 2;
    tick();

    // Video and CPU write rise together: video first
    exp_mem.push_back(vid_txn(15'h1234));
    exp_vid.push_back(16'hD108);
    exp_mem.push_back('{we: 1'b1, addr: 22'h00022B, be: 2'b01, wdata: 16'h3C3C});
    push_cpu(1'b0, 8'h00);
    vid_addr = 15'h1234; vid_req = 1'b1;
    cpu_addr = 23'h000456; cpu_din = 8'h3C; cpu_wr = 1'b1;
    tick();
    vid_req = 1'b0;
    wait_cpu_ack("wr_ack_seen", 100);
    cpu_wr = 1'b0;
    tick();

    // Reset in the middle of a CPU read's WAIT
    no_ack = 1'b1;
    exp_mem.push_back(byte_txn(1'b0, 23'h000004, 8'h00));
    cpu_addr = 23'h000004; cpu_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_bus.mem_req) break;
    end
    check("abort_req_seen", 32'(mem_bus.mem_req), 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("abort_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("abort_cpu_dout", 32'(cpu_dout), 32'hFF);
    cpu_rd = 1'b0; no_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    a0 = cpu_ack_cnt;
    repeat (10) tick();
    check("abort_no_ack", 32'(cpu_ack_cnt), 32'(a0));

    // Loader strobe while busy is ignored
    exp_mem.push_back('{we: 1'b1, addr: 22'h0091A2, be: 2'b10, wdata: 16'h7777});
    t0 = txn_cnt;
    ld_addr = 23'h012345; ld_data = 8'h77; ld_wr = 1'b1;
    tick();
    ld_addr = 23'h000222; ld_data = 8'h11;
    check("ld_busy_set", 32'(ld_busy), 32'd1);
    tick();
    ld_wr = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_bus.mem_ack) break;
    end
    check("ld_ack_seen", 32'(mem_bus.mem_ack), 32'd1);
    check("ld_busy_at_ack", 32'(ld_busy), 32'd1);
    @(negedge clk);
    check("ld_busy_after_ack", 32'(ld_busy), 32'd0);
    repeat (10) tick();
    check("ld_single_write", 32'(txn_cnt), 32'(t0 + 1));

    // Loader aging: promoted after exactly AGE_LIMIT CPU grants
    for (int k = 1; k <= 8; k++) begin
      exp_mem.push_back(byte_txn(1'b0, 23'h000200, 8'h00));
      push_cpu(1'b1, 8'h3C);
      exp_mem.push_back(vid_txn(15'h0010));
      exp_vid.push_back(16'hC32C);
    end
    exp_mem.push_back('{we: 1'b1, addr: 22'h000180, be: 2'b10, wdata: 16'h9999});
    exp_mem.push_back(byte_txn(1'b0, 23'h000200, 8'h00));
    push_cpu(1'b1, 8'h3C);
    cpu_addr = 23'h000200; vid_addr = 15'h0010;
    ld_addr = 23'h000301; ld_data = 8'h99;
    cpu_rd = 1'b1; ld_wr = 1'b1;
    tick();
    ld_wr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      wait_cpu_ack("age_cpu_ack", 100);
      if (k < 9) begin
        vid_req = 1'b1; cpu_rd = 1'b0;
        tick();
        vid_req = 1'b0; cpu_rd = 1'b1;
      end else begin
        cpu_rd = 1'b0;
      end
    end
    tick();
    check("age_ld_done", 32'(ld_busy), 32'd0);

`ifdef MEM_WATCHDOG_EN
    // Memory never answers: watchdog completes the read with FF
    no_ack = 1'b1;
    exp_mem.push_back(byte_txn(1'b0, 23'h000010, 8'h00));
    push_cpu(1'b1, 8'hFF);
    cpu_addr = 23'h000010; cpu_rd = 1'b1;
    hc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mem_bus.mem_req) hc++;
      if (cpu_ack) break;
    end
    check("wd_ack_seen", 32'(cpu_ack), 32'd1);
    check("wd_req_cycles", 32'(hc), 32'd64);
    check("wd_timeout", 32'(timeout), 32'd1);
    cpu_rd = 1'b0; no_ack = 1'b0;
    tick();
    exp_mem.push_back(byte_txn(1'b0, 23'h000011, 8'h00));
    push_cpu(1'b1, 8'hC3);
    cpu_addr = 23'h000011; cpu_rd = 1'b1;
    wait_cpu_ack("wd_next_ack", 100);
    cpu_rd = 1'b0;
    check("wd_timeout_sticky", 32'(timeout), 32'd1);
`else
    hc = 0;
    check("timeout_tied_low", 32'(timeout) + 32'(hc), 32'd0);
`endif

    repeat (5) tick();
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_cpu_drained", 32'(exp_cpu.size()), 32'd0);
    check("exp_vid_drained", 32'(exp_vid.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
